transposed_convolution: RTL and testbench

Transposed (scatter) 2D convolution: the inverse-direction counterpart of the team's 3x3-kernel, 5x5-to-3x3 convolution block. It accepts a 3x3 feature map as a valid/ready stream and a 3x3 kernel through a register write port. It scatter-accumulates every input sample through the kernel into a 5x5 output map, using one multiply-accumulate per cycle. It then streams the 25 results out in raster order. It sits on the upsampling/decoder path, after the forward convolution stage.

---
 rtl/transposed_convolution.sv | 138 +++++++++++++
 tb/tb_transposed_convolution.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/transposed_convolution.sv
// Transposed (scatter) 3x3 convolution: 3x3 map in, 5x5 map out.
// One MAC per cycle into a bank of output accumulators, raster drain.
module transposed_convolution #(
  parameter int DATA_W = 8,
  parameter int IN_DIM = 3,
  parameter int K_DIM  = 3,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              k_we,
  input  logic [3:0]        k_addr,
  input  logic [DATA_W-1:0] k_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int OUT_DIM = IN_DIM + K_DIM - 1;
  localparam int N_IN    = IN_DIM * IN_DIM;
  localparam int N_K     = K_DIM * K_DIM;
  localparam int N_OUT   = OUT_DIM * OUT_DIM;
  localparam int CW      = $clog2(N_IN + 1);
  localparam int IW      = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int MW      = (K_DIM > 1) ? $clog2(K_DIM) : 1;
  localparam int OW      = $clog2(N_OUT);

  typedef enum logic [1:0] {
    ACCEPT,
    SCATTER,
    OUTPUT
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     row;
  logic [IW-1:0]     col;
  logic [MW-1:0]     m;
  logic [MW-1:0]     n;
  logic [DATA_W-1:0] x_reg;
  logic [OW-1:0]     idx;
  logic [ACC_W-1:0]  acc  [N_OUT];
  logic [DATA_W-1:0] kern [N_K];

  logic [OW-1:0]       tgt;
  logic [3:0]          kidx;
  logic [2*DATA_W-1:0] prod;
  logic                k_ok;

  always_comb begin
    tgt  = OW'((int'(row) + int'(m)) * OUT_DIM
             + int'(col) + int'(n));
    kidx = 4'(int'(m) * K_DIM + int'(n));
    prod = x_reg * kern[kidx];
    k_ok = k_we && !busy && (k_addr < 4'(N_K));
  end

  assign in_ready  = (state == ACCEPT);
  assign out_valid = (state == OUTPUT);
  assign out_last  = out_valid && (idx == OW'(N_OUT - 1));
  assign busy      = (cnt != '0) || (state != ACCEPT);
  // acc[idx] only changes on a handshake, so the mux is stall-stable
  assign out_data  = out_valid ? acc[idx] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCEPT;
      cnt   <= '0;
      row   <= '0;
      col   <= '0;
      m     <= '0;
      n     <= '0;
      x_reg <= '0;
      idx   <= '0;
      for (int a = 0; a < N_OUT; a++) acc[a] <= '0;
      for (int a = 0; a < N_K; a++) kern[a] <= '0;
    end else begin
      if (k_ok) kern[k_addr] <= k_data;
      unique case (state)
        ACCEPT: begin
          if (in_valid) begin
            x_reg <= in_data;
            m     <= '0;
            n     <= '0;
            state <= SCATTER;
          end
        end
        SCATTER: begin
          acc[tgt] <= acc[tgt] + ACC_W'(prod);
          if (n == MW'(K_DIM - 1)) begin
            n <= '0;
            if (m == MW'(K_DIM - 1)) begin
              m   <= '0;
              cnt <= cnt + 1'b1;
              if (col == IW'(IN_DIM - 1)) begin
                col <= '0;
                row <= (row == IW'(IN_DIM - 1)) ? '0 : row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
              if (cnt == CW'(N_IN - 1)) begin
                idx   <= '0;
                state <= OUTPUT;
              end else begin
                state <= ACCEPT;
              end
            end else begin
              m <= m + 1'b1;
            end
          end else begin
            n <= n + 1'b1;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            acc[idx] <= '0;
            if (idx == OW'(N_OUT - 1)) begin
              idx   <= '0;
              cnt   <= '0;
              row   <= '0;
              col   <= '0;
              state <= ACCEPT;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= ACCEPT;
      endcase
    end
  end

endmodule

// File: tb/tb_transposed_convolution.sv
// Directed bench for transposed_convolution: identity, saturating,
// stalled, back-to-back, kernel-lock and mid-frame reset scenarios.
module tb_transposed_convolution;

  logic        clk = 1'b0;
  logic        rst;
  logic        k_we;
  logic [3:0]  k_addr;
  logic [7:0]  k_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_data;
  logic        out_last;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [19:0] exp_map [25];
  logic [7:0]  in_vec  [9];
  int          w5      [5] = '{1, 2, 3, 2, 1};

  transposed_convolution dut (
    .clk      (clk),
    .rst      (rst),
    .k_we     (k_we),
    .k_addr   (k_addr),
    .k_data   (k_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr_k(input logic [3:0] a, input logic [7:0] d);
    k_we = 1'b1;
    k_addr = a;
    k_data = d;
    @(posedge clk);
    @(negedge clk);
    k_we = 1'b0;
  endtask

  task automatic load_kernel(input logic [7:0] ctr,
                             input logic [7:0] rest);
    for (int a = 0; a < 9; a++)
      wr_k(4'(a), (a == 4) ? ctr : rest);
  endtask

  task automatic set_identity(input int scale);
    for (int a = 0; a < 25; a++) exp_map[a] = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        exp_map[(i + 1) * 5 + j + 1] = 20'(scale * (i * 3 + j + 1));
    for (int a = 0; a < 9; a++) in_vec[a] = 8'(a + 1);
  endtask

  task automatic set_full();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        exp_map[r * 5 + c] = 20'(w5[r] * w5[c] * 65025);
    for (int a = 0; a < 9; a++) in_vec[a] = 8'd255;
  endtask

  // starts and ends just after a falling edge
  task automatic send_sample(input logic [7:0] x, input bit last,
                             input bit stall);
    if (stall)
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        @(negedge clk);
      end
    check("in_ready_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data = x;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      check($sformatf("in_ready_scatter%0d", k), 32'(in_ready), 32'd0);
      if (last)
        check($sformatf("out_valid_early%0d", k), 32'(out_valid), 32'd0);
      if (stall) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data = 8'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
    end
    check("in_ready_after", 32'(in_ready), last ? 32'd0 : 32'd1);
    check("out_valid_after", 32'(out_valid), last ? 32'd1 : 32'd0);
  endtask

  task automatic recv_frame(input bit stall);
    int beat = 0;
    int cyc = 0;
    bit held = 1'b0;
    logic [19:0] hd = '0;
    logic hl = 1'b0;
    while (beat < 25 && cyc < 2000) begin
      if (held) begin
        check("hold_data", 32'(out_data), 32'(hd));
        check("hold_last", 32'(out_last), 32'(hl));
      end
      held = 1'b0;
      if (out_valid) begin
        out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (out_ready) begin
          check($sformatf("out_data[%0d]", beat), 32'(out_data),
                32'(exp_map[beat]));
          check($sformatf("out_last[%0d]", beat), 32'(out_last),
                (beat == 24) ? 32'd1 : 32'd0);
          beat++;
        end else begin
          held = 1'b1;
          hd = out_data;
          hl = out_last;
        end
      end else begin
        out_ready = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    check("out_beats", 32'(beat), 32'd25);
    check("out_valid_done", 32'(out_valid), 32'd0);
    check("busy_done", 32'(busy), 32'd0);
    check("in_ready_done", 32'(in_ready), 32'd1);
  endtask

  task automatic run_frame(input bit stall, input bit bad_wr);
    for (int s = 0; s < 9; s++) begin
      send_sample(in_vec[s], s == 8, stall);
      if (bad_wr && s == 3) begin
        check("busy_mid", 32'(busy), 32'd1);
        wr_k(4'd4, 8'd7);
      end
    end
    recv_frame(stall);
  endtask

  initial begin
    rst = 1'b1;
    k_we = 1'b0;
    k_addr = '0;
    k_data = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // identity frame; a mid-frame kernel write must be dropped
    wr_k(4'd4, 8'd1);
    set_identity(1);
    run_frame(1'b0, 1'b1);

    // same write while idle takes effect
    wr_k(4'd4, 8'd7);
    set_identity(7);
    run_frame(1'b0, 1'b0);

    // worst-case magnitudes, then again under random stalls
    load_kernel(8'd255, 8'd255);
    set_full();
    run_frame(1'b0, 1'b0);
    run_frame(1'b1, 1'b0);

    // back-to-back: no residue from the previous frame
    load_kernel(8'd1, 8'd0);
    set_identity(1);
    run_frame(1'b0, 1'b0);

    // reset on the 4th scatter cycle of sample 5
    for (int s = 0; s < 4; s++) send_sample(in_vec[s], 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data = in_vec[4];
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_out_data", 32'(out_data), 32'd0);

    // kernel cleared by reset: all-zero output
    set_identity(0);
    run_frame(1'b0, 1'b0);

    wr_k(4'd4, 8'd1);
    set_identity(1);
    run_frame(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
